m_boot_mem: RTL and testbench

- Parametrised successor to the core-side IMEM/DMEM pair: one unified, byte-writable, dual-port RAM with a built-in byte-stream boot loader.
- After reset, a loader FSM accepts program bytes on a valid/ready stream, assembles them little-endian into words and writes them from address 0 upward.
- Core reset stays asserted until loading completes.
- Port I serves instruction fetch; port D serves core load/store.

---
 rtl/m_boot_mem_pkg.sv | 14 +
 rtl/m_bm_ram.sv | 54 +++++
 rtl/m_boot_mem.sv | 142 ++++++++++++++
 tb/tb_m_boot_mem.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_boot_mem_pkg.sv
// Shared types for the boot-loading unified memory: loader state encoding and sizing helper.
package m_boot_mem_pkg;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } bm_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/m_bm_ram.sv
// Unified byte-writable RAM: loader write path until done, then fetch port I and load/store port D.
module m_bm_ram
  import m_boot_mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ENTRY = 256,
  parameter int AW    = $clog2(ENTRY)
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic               i_done,
  input  logic               i_ld_we,
  input  logic [AW-1:0]      i_ld_addr,
  input  logic [WIDTH-1:0]   i_ld_wdata,
  input  logic               I_EN,
  input  logic [AW-1:0]      I_ADDR,
  output logic [WIDTH-1:0]   I_DATA,
  input  logic               D_EN,
  input  logic [WIDTH/8-1:0] D_WE,
  input  logic [AW-1:0]      D_ADDR,
  input  logic [WIDTH-1:0]   D_WDATA,
  output logic [WIDTH-1:0]   D_RDATA
);

  logic [WIDTH-1:0] r_mem [ENTRY];
  logic [AW-1:0]    r_iaddr;
  logic [WIDTH-1:0] r_drdata;

  // Storage is never reset so an image survives a mid-load reset.
  always_ff @(posedge CLK) begin
    if (!i_done) begin
      if (i_ld_we) r_mem[i_ld_addr] <= i_ld_wdata;
    end else if (D_EN) begin
      for (int b = 0; b < WIDTH/8; b++) begin
        if (D_WE[b]) r_mem[D_ADDR][8*b +: 8] <= D_WDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_iaddr  <= '0;
      r_drdata <= '0;
    end else if (i_done) begin
      if (I_EN) r_iaddr <= I_ADDR;
      if (D_EN) r_drdata <= r_mem[D_ADDR];
    end
  end

  // Fetch reads through the latched address, so a same-edge D write is visible at once.
  assign I_DATA  = r_mem[r_iaddr];
  assign D_RDATA = r_drdata;

endmodule

// File: rtl/m_boot_mem.sv
// Boot memory top: byte-stream loader FSM, word assembler and core reset release.
// Define MEM_BOOT_SKIP_EN to drop the loader and start in the done state (memory preloaded externally).
module m_boot_mem
  import m_boot_mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ENTRY    = 256,
  parameter int LOAD_MAX = ENTRY
) (
  input  logic                     CLK,
  input  logic                     RST_X,
  input  logic                     LD_VALID,
  output logic                     LD_READY,
  input  logic [7:0]               LD_BYTE,
  input  logic                     LD_LAST,
  output logic                     LD_DONE,
  output logic                     CORE_RST_X,
  input  logic                     I_EN,
  input  logic [$clog2(ENTRY)-1:0] I_ADDR,
  output logic [WIDTH-1:0]         I_DATA,
  input  logic                     D_EN,
  input  logic [WIDTH/8-1:0]       D_WE,
  input  logic [$clog2(ENTRY)-1:0] D_ADDR,
  input  logic [WIDTH-1:0]         D_WDATA,
  output logic [WIDTH-1:0]         D_RDATA
);

  localparam int AW    = $clog2(ENTRY);
  localparam int BYTES = WIDTH / 8;
  localparam int BCW   = cnt_w(BYTES);

  logic             w_ready;
  logic             w_done;
  logic             w_ld_we;
  logic [AW-1:0]    w_ld_addr;
  logic [WIDTH-1:0] w_ld_wdata;
  logic             r_core_rst_x;

`ifdef MEM_BOOT_SKIP_EN
  logic w_unused;
  assign w_unused   = ^{LD_VALID, LD_BYTE, LD_LAST};
  assign w_ready    = 1'b0;
  assign w_done     = 1'b1;
  assign w_ld_we    = 1'b0;
  assign w_ld_addr  = '0;
  assign w_ld_wdata = '0;
`else
  localparam logic [AW:0] LAST_PTR = (AW+1)'(LOAD_MAX - 1);

  bm_state_e        r_state;
  logic [AW:0]      r_wptr;
  logic [BCW-1:0]   r_bcnt;
  logic [WIDTH-1:0] r_asm;
  logic             r_last;
  logic             r_ready;
  logic             r_done;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state <= S_LOAD;
      r_wptr  <= '0;
      r_bcnt  <= '0;
      r_asm   <= '0;
      r_last  <= 1'b0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_ready <= 1'b1;
          if (LD_VALID && r_ready) begin
            for (int b = 0; b < BYTES; b++) begin
              if (r_bcnt == BCW'(b)) r_asm[8*b +: 8] <= LD_BYTE;
            end
            if (LD_LAST || r_bcnt == BCW'(BYTES - 1)) begin
              r_state <= S_WRITE;
              r_ready <= 1'b0;
              r_last  <= LD_LAST;
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
        end
        // Unfilled lanes of a short final word are still zero from the previous clear.
        S_WRITE: begin
          r_asm  <= '0;
          r_bcnt <= '0;
          if (r_last || r_wptr == LAST_PTR) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_wptr  <= r_wptr + 1'b1;
            r_state <= S_LOAD;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_done  <= 1'b1;
        end
      endcase
    end
  end

  assign w_ready    = r_ready;
  assign w_done     = r_done;
  assign w_ld_we    = (r_state == S_WRITE);
  assign w_ld_addr  = r_wptr[AW-1:0];
  assign w_ld_wdata = r_asm;
`endif

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) r_core_rst_x <= 1'b0;
    else        r_core_rst_x <= w_done;
  end

  assign LD_READY   = w_ready;
  assign LD_DONE    = w_done;
  assign CORE_RST_X = r_core_rst_x;

  m_bm_ram #(
    .WIDTH (WIDTH),
    .ENTRY (ENTRY),
    .AW    (AW)
  ) u_ram (
    .CLK        (CLK),
    .RST_X      (RST_X),
    .i_done     (w_done),
    .i_ld_we    (w_ld_we),
    .i_ld_addr  (w_ld_addr),
    .i_ld_wdata (w_ld_wdata),
    .I_EN       (I_EN),
    .I_ADDR     (I_ADDR),
    .I_DATA     (I_DATA),
    .D_EN       (D_EN),
    .D_WE       (D_WE),
    .D_ADDR     (D_ADDR),
    .D_WDATA    (D_WDATA),
    .D_RDATA    (D_RDATA)
  );

endmodule

// File: tb/tb_m_boot_mem.sv
// Bench for m_boot_mem: directed boot images, backpressure, overflow, mid-load reset and random D/I traffic.
module tb_m_boot_mem;

  localparam int WIDTH = 32;
  localparam int ENTRY = 256;
  localparam int AW    = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             RST_X = 1'b1;
  logic             LD_VALID = 1'b0, LD_LAST = 1'b0;
  logic [7:0]       LD_BYTE = '0;
  logic             LD_READY, LD_DONE, CORE_RST_X;
  logic             I_EN = 1'b0;
  logic [AW-1:0]    I_ADDR = '0;
  logic [WIDTH-1:0] I_DATA;
  logic             D_EN = 1'b0;
  logic [3:0]       D_WE = '0;
  logic [AW-1:0]    D_ADDR = '0;
  logic [WIDTH-1:0] D_WDATA = '0;
  logic [WIDTH-1:0] D_RDATA;

  logic             o_rst_x = 1'b1;
  logic             o_ld_valid = 1'b0, o_ld_last = 1'b0;
  logic [7:0]       o_ld_byte = '0;
  logic             o_ld_ready, o_ld_done, o_core_rst_x;
  logic             o_i_en = 1'b0;
  logic [AW-1:0]    o_i_addr = '0;
  logic [WIDTH-1:0] o_i_data;
  logic             o_d_en = 1'b0;
  logic [3:0]       o_d_we = '0;
  logic [AW-1:0]    o_d_addr = '0;
  logic [WIDTH-1:0] o_d_wdata = '0;
  logic [WIDTH-1:0] o_d_rdata;

  m_boot_mem #(.WIDTH(WIDTH), .ENTRY(ENTRY)) u_dut (
    .CLK(CLK), .RST_X(RST_X), .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_BYTE(LD_BYTE),
    .LD_LAST(LD_LAST), .LD_DONE(LD_DONE), .CORE_RST_X(CORE_RST_X), .I_EN(I_EN), .I_ADDR(I_ADDR),
    .I_DATA(I_DATA), .D_EN(D_EN), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_RDATA(D_RDATA)
  );

  m_boot_mem #(.WIDTH(WIDTH), .ENTRY(ENTRY), .LOAD_MAX(2)) u_ovf (
    .CLK(CLK), .RST_X(o_rst_x), .LD_VALID(o_ld_valid), .LD_READY(o_ld_ready), .LD_BYTE(o_ld_byte),
    .LD_LAST(o_ld_last), .LD_DONE(o_ld_done), .CORE_RST_X(o_core_rst_x), .I_EN(o_i_en),
    .I_ADDR(o_i_addr), .I_DATA(o_i_data), .D_EN(o_d_en), .D_WE(o_d_we), .D_ADDR(o_d_addr),
    .D_WDATA(o_d_wdata), .D_RDATA(o_d_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_mem [ENTRY];
  logic [AW-1:0]    model_iaddr = '0;
  int               model_words = 0;

  // Word w of an image is bytes 4w..4w+3, little-endian, missing bytes zero.
  function automatic logic [31:0] pack_word(input logic [7:0] q[$], input int w);
    logic [31:0] word = 32'h0;
    for (int k = 0; k < 4; k++)
      if (4*w + k < q.size()) word = word | (32'(q[4*w + k]) << (8*k));
    return word;
  endfunction

  function automatic void model_load(input logic [7:0] q[$], input int load_max);
    int n = (q.size() + 3) / 4;
    if (n > load_max) n = load_max;
    for (int w = 0; w < n; w++) model_mem[w] = pack_word(q, w);
    if (n > model_words) model_words = n;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RST_X = 1'b0; LD_VALID = 1'b0; LD_LAST = 1'b0; LD_BYTE = '0;
    I_EN = 1'b0; D_EN = 1'b0; D_WE = '0;
    model_iaddr = '0;
    @(negedge CLK);
    RST_X = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic last);
    bit ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      LD_VALID = 1'b1; LD_BYTE = b; LD_LAST = last;
      if (LD_READY === 1'b1) begin
        ok = 1;
        @(posedge CLK);
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept byte=%h never accepted, required accept within 20 cycles", b);
    end
  endtask

  task automatic finish_load();
    @(negedge CLK);
    LD_VALID = 1'b0; LD_LAST = 1'b0;
    for (int c = 0; c < 10 && LD_DONE !== 1'b1; c++) @(negedge CLK);
    checks++;
    if (LD_DONE !== 1'b1) begin
      errors++;
      $display("FAIL load_done got %b required 1", LD_DONE);
    end
  endtask

  task automatic read_i(input logic [AW-1:0] a, output logic [WIDTH-1:0] d);
    @(negedge CLK);
    I_EN = 1'b1; I_ADDR = a;
    @(negedge CLK);
    I_EN = 1'b0;
    model_iaddr = a;
    d = I_DATA;
  endtask

  task automatic test_reset();
    #2 RST_X = 1'b0; o_rst_x = 1'b0;
    @(negedge CLK);
    checks += 4;
    if (LD_READY !== 1'b0) begin errors++; $display("FAIL rst_ready got %b required 0", LD_READY); end
    if (LD_DONE !== 1'b0) begin errors++; $display("FAIL rst_done got %b required 0", LD_DONE); end
    if (CORE_RST_X !== 1'b0) begin errors++; $display("FAIL rst_core got %b required 0", CORE_RST_X); end
    if (D_RDATA !== 32'h0) begin errors++; $display("FAIL rst_drdata got %h required 0", D_RDATA); end
    @(negedge CLK);
    RST_X = 1'b1;
    @(negedge CLK);
    checks += 2;
    if (LD_READY !== 1'b1) begin errors++; $display("FAIL rst_ready_rise got %b required 1", LD_READY); end
    if (LD_DONE !== 1'b0) begin errors++; $display("FAIL rst_done_low got %b required 0", LD_DONE); end
  endtask

  task automatic test_basic();
    logic [7:0] q[$];
    logic [WIDTH-1:0] d;
    q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    I_EN = 1'b1; I_ADDR = 8'd1;
    for (int i = 0; i < q.size(); i++) push_byte(q[i], i == q.size() - 1);
    @(negedge CLK);
    LD_VALID = 1'b0; LD_LAST = 1'b0;
    checks += 2;
    if (LD_READY !== 1'b0) begin errors++; $display("FAIL basic_write_ready got %b required 0", LD_READY); end
    if (LD_DONE !== 1'b0) begin errors++; $display("FAIL basic_write_done got %b required 0", LD_DONE); end
    @(negedge CLK);
    I_EN = 1'b0;
    model_load(q, ENTRY);
    checks += 3;
    if (LD_DONE !== 1'b1) begin errors++; $display("FAIL basic_done got %b required 1", LD_DONE); end
    if (CORE_RST_X !== 1'b0) begin errors++; $display("FAIL basic_core_early got %b required 0", CORE_RST_X); end
    if (I_DATA !== model_mem[0]) begin errors++; $display("FAIL basic_fetch_ignored got %h required %h", I_DATA, model_mem[0]); end
    @(negedge CLK);
    checks++;
    if (CORE_RST_X !== 1'b1) begin errors++; $display("FAIL basic_core_rise got %b required 1", CORE_RST_X); end
    for (int w = 0; w < 2; w++) begin
      read_i(AW'(w), d);
      checks++;
      if (d !== model_mem[w]) begin errors++; $display("FAIL basic_mem%0d got %h required %h", w, d, model_mem[w]); end
    end
  endtask

  task automatic test_dport();
    logic [WIDTH-1:0] old;
    @(negedge CLK);
    D_EN = 1'b1; D_WE = 4'b0010; D_ADDR = 8'd0; D_WDATA = 32'h0000CC00;
    I_EN = 1'b1; I_ADDR = 8'd0;
    old = model_mem[0];
    model_mem[0][15:8] = 8'hCC;
    model_iaddr = '0;
    @(negedge CLK);
    D_EN = 1'b0; I_EN = 1'b0;
    checks += 2;
    if (D_RDATA !== old) begin errors++; $display("FAIL dport_rdata got %h required %h", D_RDATA, old); end
    if (I_DATA !== model_mem[0]) begin errors++; $display("FAIL dport_collision got %h required %h", I_DATA, model_mem[0]); end
    @(negedge CLK);
    checks++;
    if (D_RDATA !== old) begin errors++; $display("FAIL dport_hold got %h required %h", D_RDATA, old); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] q[$];
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] keep1;
    do_reset();
    for (int i = 0; i < 3; i++) push_byte(8'($urandom), 1'b0);
    do_reset();
    keep1 = model_mem[1];
    D_EN = 1'b1; D_WE = 4'hF; D_ADDR = 8'd1; D_WDATA = 32'hFFFF_FFFF;
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) push_byte(q[i], i == 3);
    @(negedge CLK);
    D_EN = 1'b0; D_WE = '0; LD_VALID = 1'b0; LD_LAST = 1'b0;
    checks++;
    if (D_RDATA !== 32'h0) begin errors++; $display("FAIL midrst_drdata_blocked got %h required 0", D_RDATA); end
    finish_load();
    model_load(q, ENTRY);
    read_i(8'd0, d);
    checks++;
    if (d !== model_mem[0]) begin errors++; $display("FAIL midrst_mem0 got %h required %h", d, model_mem[0]); end
    read_i(8'd1, d);
    checks++;
    if (d !== keep1) begin errors++; $display("FAIL midrst_mem1 got %h required %h", d, keep1); end
  endtask

  task automatic test_partial();
    logic [7:0] q[$];
    logic [WIDTH-1:0] d;
    do_reset();
    q = '{8'hAA, 8'hBB};
    push_byte(q[0], 1'b0);
    push_byte(q[1], 1'b1);
    finish_load();
    model_load(q, ENTRY);
    for (int w = 0; w < 2; w++) begin
      read_i(AW'(w), d);
      checks++;
      if (d !== model_mem[w]) begin errors++; $display("FAIL partial_mem%0d got %h required %h", w, d, model_mem[w]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] q[$];
    logic [WIDTH-1:0] d;
    int idx = 0;
    int prev = -1;
    int cyc = 0;
    logic rdy;
    do_reset();
    for (int i = 0; i < 8; i++) q.push_back(8'(i + 1));
    while (idx < 8 && cyc < 40) begin
      @(negedge CLK);
      rdy = LD_READY;
      if (prev >= 0) begin
        checks++;
        if (rdy !== ((prev % 4) != 3)) begin
          errors++;
          $display("FAIL bp_ready_after_byte%0d got %b required %b", prev, rdy, (prev % 4) != 3);
        end
      end
      LD_VALID = 1'b1; LD_BYTE = q[idx]; LD_LAST = (idx == 7);
      @(posedge CLK);
      if (rdy === 1'b1) begin prev = idx; idx++; end
      else prev = -1;
      cyc++;
    end
    @(negedge CLK);
    LD_VALID = 1'b0; LD_LAST = 1'b0;
    checks += 2;
    if (idx != 8) begin errors++; $display("FAIL bp_accepted got %0d required 8", idx); end
    if (LD_READY !== 1'b0) begin errors++; $display("FAIL bp_ready_last got %b required 0", LD_READY); end
    finish_load();
    model_load(q, ENTRY);
    for (int w = 0; w < 2; w++) begin
      read_i(AW'(w), d);
      checks++;
      if (d !== model_mem[w]) begin errors++; $display("FAIL bp_mem%0d got %h required %h", w, d, model_mem[w]); end
    end
  endtask

  task automatic test_random_load();
    logic [7:0] q[$];
    logic [WIDTH-1:0] d;
    int n;
    int gap;
    do_reset();
    n = $urandom_range(33, 64);
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge CLK);
        LD_VALID = 1'b0;
      end
      push_byte(q[i], i == n - 1);
    end
    finish_load();
    model_load(q, ENTRY);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      LD_VALID = 1'b1; LD_BYTE = 8'h5A;
      checks++;
      if (LD_READY !== 1'b0) begin errors++; $display("FAIL rnd_ready_after_done got %b required 0", LD_READY); end
    end
    @(negedge CLK);
    LD_VALID = 1'b0;
    for (int w = 0; w < (n + 3) / 4; w++) begin
      read_i(AW'(w), d);
      checks++;
      if (d !== model_mem[w]) begin errors++; $display("FAIL rnd_mem%0d got %h required %h", w, d, model_mem[w]); end
    end
  endtask

  task automatic test_dport_random();
    logic [WIDTH-1:0] exp_rd;
    logic en, ie;
    logic [3:0] we;
    logic [AW-1:0] da, ia;
    logic [WIDTH-1:0] wd;
    exp_rd = D_RDATA;
    for (int op = 0; op < 40; op++) begin
      en = ($urandom_range(0, 3) != 0);
      ie = $urandom_range(0, 1);
      we = 4'($urandom);
      wd = $urandom;
      da = AW'($urandom_range(0, model_words - 1));
      ia = AW'($urandom_range(0, model_words - 1));
      if ($urandom_range(0, 3) == 0) ia = da;
      @(negedge CLK);
      D_EN = en; D_WE = we; D_ADDR = da; D_WDATA = wd; I_EN = ie; I_ADDR = ia;
      if (en) begin
        exp_rd = model_mem[da];
        for (int b = 0; b < 4; b++) if (we[b]) model_mem[da][8*b +: 8] = wd[8*b +: 8];
      end
      if (ie) model_iaddr = ia;
      @(negedge CLK);
      D_EN = 1'b0; I_EN = 1'b0;
      checks += 2;
      if (D_RDATA !== exp_rd) begin errors++; $display("FAIL drnd_rdata op%0d got %h required %h", op, D_RDATA, exp_rd); end
      if (I_DATA !== model_mem[model_iaddr]) begin
        errors++;
        $display("FAIL drnd_idata op%0d got %h required %h", op, I_DATA, model_mem[model_iaddr]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] q[$];
    int idx = 0;
    logic rdy;
    for (int i = 0; i < 12; i++) q.push_back(8'(8'h10 + i));
    @(negedge CLK);
    o_rst_x = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      rdy = o_ld_ready;
      o_ld_valid = (idx < 12);
      o_ld_byte = (idx < 12) ? q[idx] : 8'h00;
      @(posedge CLK);
      if (rdy === 1'b1 && idx < 12) idx++;
    end
    @(negedge CLK);
    checks += 4;
    if (idx != 8) begin errors++; $display("FAIL ovf_accepted got %0d required 8", idx); end
    if (o_ld_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got %b required 0", o_ld_ready); end
    if (o_ld_done !== 1'b1) begin errors++; $display("FAIL ovf_done got %b required 1", o_ld_done); end
    if (o_core_rst_x !== 1'b1) begin errors++; $display("FAIL ovf_core got %b required 1", o_core_rst_x); end
    o_ld_valid = 1'b0;
    for (int w = 0; w < 2; w++) begin
      @(negedge CLK);
      o_i_en = 1'b1; o_i_addr = AW'(w);
      @(negedge CLK);
      o_i_en = 1'b0;
      checks++;
      if (o_i_data !== pack_word(q, w)) begin
        errors++;
        $display("FAIL ovf_mem%0d got %h required %h", w, o_i_data, pack_word(q, w));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_dport();
    test_mid_reset();
    test_partial();
    test_backpressure();
    test_random_load();
    test_dport_random();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
